// File: rtl/alu_pkg.sv
// Shared types and sizes for the arithmetic-unit dispatcher and the unit wrappers.
package alu_pkg;
  localparam int DATA_W    = 64;
  localparam int NUM_UNITS = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FREE = 3'd1,
    ISSUE     = 3'd2,
    WAIT_ACK  = 3'd3,
    RESP      = 3'd4
  } disp_state_e;

  function automatic logic [NUM_UNITS-1:0] op_onehot(input op_e op);
    logic [NUM_UNITS-1:0] oh;
    oh     = '0;
    oh[op] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/alu_op_dispatcher_if.sv
// Command, response and unit-side signals of the dispatcher.
// slave is the dispatcher's view; master is the host plus the four units.
interface alu_op_dispatcher_if;
  import alu_pkg::*;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [1:0]                  cmd_op;
  logic [DATA_W-1:0]           cmd_a;
  logic [DATA_W-1:0]           cmd_b;
  logic [NUM_UNITS-1:0]        unit_start;
  logic [DATA_W-1:0]           unit_a;
  logic [DATA_W-1:0]           unit_b;
  logic [NUM_UNITS-1:0]        unit_working;
  logic [NUM_UNITS-1:0]        unit_ack;
  logic [NUM_UNITS*DATA_W-1:0] unit_result;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [DATA_W-1:0]           rsp_result;
  logic [1:0]                  rsp_op;
  logic                        rsp_err;
  logic                        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, unit_working, unit_ack, unit_result, rsp_ready,
    input  cmd_ready, unit_start, unit_a, unit_b, rsp_valid, rsp_result, rsp_op, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, unit_working, unit_ack, unit_result, rsp_ready,
    output cmd_ready, unit_start, unit_a, unit_b, rsp_valid, rsp_result, rsp_op, rsp_err, busy
  );
endinterface

// File: rtl/result_mux.sv
// Selects the 64-bit result slice of the unit addressed by op.
module result_mux
  import alu_pkg::*;
(
  input  op_e                         op,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
  output logic [DATA_W-1:0]           result
);

  // Slice select by op code.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = unit_result[0*DATA_W +: DATA_W];
      OP_SUB:  result = unit_result[1*DATA_W +: DATA_W];
      OP_MUL:  result = unit_result[2*DATA_W +: DATA_W];
      OP_DIV:  result = unit_result[3*DATA_W +: DATA_W];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Initiator for the arithmetic-unit start/working/ack protocol: one command in
// flight, busy-unit wait, hung-unit timeout, registered response.
module alu_op_dispatcher
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input logic                clk,
  input logic                rst,
  alu_op_dispatcher_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  disp_state_e       state_r;
  disp_state_e       state_s;
  op_e               op_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] unit_a_r;
  logic [DATA_W-1:0] unit_b_r;
  logic [DATA_W-1:0] rsp_result_r;
  logic [DATA_W-1:0] sel_result_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              rsp_err_r;
  logic              ack_sel_s;
  logic              working_sel_s;
  logic              timeout_s;

  result_mux u_result_mux (
    .op          (op_r),
    .unit_result (bus.unit_result),
    .result      (sel_result_s)
  );

  // Only the selected unit's handshake bits are ever looked at.
  assign ack_sel_s     = bus.unit_ack[op_r];
  assign working_sel_s = bus.unit_working[op_r];
  assign timeout_s     = (cnt_r == CNT_LAST);

  assign bus.unit_a     = unit_a_r;
  assign bus.unit_b     = unit_b_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.rsp_op     = op_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; an ack beats both the timeout and the working flag.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) state_s = WAIT_FREE;
        else               state_s = IDLE;
      end
      WAIT_FREE: begin
        if (timeout_s)          state_s = RESP;
        else if (working_sel_s) state_s = WAIT_FREE;
        else                    state_s = ISSUE;
      end
      ISSUE: begin
        if (ack_sel_s)          state_s = RESP;
        else if (timeout_s)     state_s = RESP;
        else if (working_sel_s) state_s = WAIT_ACK;
        else                    state_s = ISSUE;
      end
      WAIT_ACK: begin
        if (ack_sel_s)      state_s = RESP;
        else if (timeout_s) state_s = RESP;
        else                state_s = WAIT_ACK;
      end
      RESP: begin
        if (bus.rsp_ready) state_s = IDLE;
        else               state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake and start outputs, decoded from state only.
  always_comb begin
    bus.cmd_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.busy       = 1'b1;
    bus.unit_start = '0;
    case (state_r)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      ISSUE:   bus.unit_start = op_onehot(op_r);
      RESP:    bus.rsp_valid  = 1'b1;
      default: bus.busy       = 1'b1;
    endcase
  end

  // Command latch, operand broadcast, timeout counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r         <= OP_ADD;
      a_r          <= '0;
      b_r          <= '0;
      unit_a_r     <= '0;
      unit_b_r     <= '0;
      cnt_r        <= '0;
      rsp_result_r <= '0;
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_r  <= op_e'(bus.cmd_op);
            a_r   <= bus.cmd_a;
            b_r   <= bus.cmd_b;
            cnt_r <= '0;
          end
        end
        WAIT_FREE: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (timeout_s) begin
            rsp_result_r <= '0;
            rsp_err_r    <= 1'b1;
          end else if (!working_sel_s) begin
            // Operands appear on the unit bus together with start.
            unit_a_r <= a_r;
            unit_b_r <= b_r;
          end
        end
        ISSUE, WAIT_ACK: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (ack_sel_s) begin
            rsp_result_r <= sel_result_s;
            rsp_err_r    <= 1'b0;
          end else if (timeout_s) begin
            rsp_result_r <= '0;
            rsp_err_r    <= 1'b1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_op_dispatcher.md
Name: alu_op_dispatcher

Overview:
- Initiator side of the arithmetic-unit start/working/ack protocol. Accepts one command at a time (op, a, b) over a valid/ready interface.
- Issues the command to the selected unit (add, sub, mul or div), waits for that unit's ack, and returns the captured 64-bit result over a valid/ready response interface.
- Sits between the host/command front end and the four arithmetic units. Guards against busy units and hung units with a timeout.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles from command accept to unit ack before the op is aborted with an error; must be >= 2.
- CNT_W, 16: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  Single clock; all logic on rising edge.
- rst  in  1  Synchronous, active-high reset.
- cmd_valid  in  1  Command present.
- cmd_ready  out  1  Dispatcher can accept a command.
- cmd_op  in  2  Op select: 0=add, 1=sub, 2=mul, 3=div.
- cmd_a  in  64  Operand A.
- cmd_b  in  64  Operand B.
- unit_start  out  4  One-hot start to each unit, indexed by op code.
- unit_a  out  64  Operand A broadcast to the units.
- unit_b  out  64  Operand B broadcast to the units.
- unit_working  in  4  Per-unit working flag.
- unit_ack  in  4  Per-unit completion ack.
- unit_result  in  256  Concatenated unit results; op k occupies bits [64k+63:64k].
- rsp_valid  out  1  Response present.
- rsp_ready  in  1  Consumer accepts the response.
- rsp_result  out  64  Captured result; 0 on error.
- rsp_op  out  2  Op code of the response.
- rsp_err  out  1  1 = timeout abort.
- busy  out  1  High in every state except IDLE.

Behaviour:
- Reset (synchronous): state=IDLE. All outputs 0 except cmd_ready=1 (cmd_ready is combinational from the IDLE state). Latched op, operands, result and counter are cleared. Reset mid-operation aborts silently: unit_start drops on the next cycle and no response is produced.
- IDLE: cmd_ready=1. When cmd_valid && cmd_ready, latch op/a/b, clear the counter and go to WAIT_FREE. No combinational path from cmd_valid to unit_start.
- WAIT_FREE: if unit_working[op]==0, go to ISSUE; otherwise stay.
- ISSUE:
  - unit_start[op]=1; all other start bits stay 0.
  - unit_a/unit_b drive the latched operands.
  - If unit_ack[op]=1, capture unit_result slice op and go to RESP. Ack has priority over working in the same cycle.
  - Else if unit_working[op]=1, go to WAIT_ACK.
  - Else hold start and stay.
- WAIT_ACK: start is 0 and operands are held. On unit_ack[op], capture the result and go to RESP.
- RESP: rsp_valid=1, with rsp_result/rsp_op/rsp_err stable. On rsp_ready, go to IDLE. Back-to-back: a new command is accepted no earlier than the cycle after IDLE is re-entered.
- Timeout:
  - The counter increments every cycle in WAIT_FREE, ISSUE and WAIT_ACK.
  - When counter == TIMEOUT_CYCLES-1 and no ack[op] arrives that cycle, go to RESP with rsp_err=1, rsp_result=0.
  - An ack arriving on that same cycle wins: normal response, err=0.
- Acks and working bits of non-selected units are ignored in every state. Any ack seen in IDLE or RESP is ignored.
- unit_a/unit_b keep their last value outside ISSUE/WAIT_ACK; they reset to 0.
- Minimum latency, accept to rsp_valid, is 3 cycles when the unit is free and acks in the first ISSUE cycle: accept edge → WAIT_FREE → ISSUE (ack captured) → RESP.
- Outputs are registered or decoded from state only.

Decomposition:
- Shared package alu_pkg holds:
  - the op_e enum {OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3};
  - the dispatcher state enum {IDLE, WAIT_FREE, ISSUE, WAIT_ACK, RESP};
  - DATA_W=64 and NUM_UNITS=4, reused by the unit wrappers.
- One natural sub-module: result_mux, a combinational select of the 64-bit slice of unit_result by op. Everything else stays in one FSM module.

Test Plan:
- mul, a=7, b=6, unit_working[2] low, ack[2] in the first ISSUE cycle with result slice 42 → unit_start=4'b0100 for exactly 1 cycle; rsp_valid 3 cycles after accept; rsp_result=42, rsp_op=2, rsp_err=0.
- div, a=100, b=5, unit_working[3] held high for 10 cycles → unit_start stays 0 for those 10 cycles; then start[3] asserts; working rises next cycle and start drops; ack after 5 more cycles with 20 → rsp_result=20.
- add issued; ack[1] and ack[0] pulsed during WAIT_ACK with slices 0xDEAD/0xBEEF → ack[1] ignored; on ack[0] rsp_result=0xBEEF.
- sub with TIMEOUT_CYCLES=8, no working/ack ever → rsp_valid in the cycle after the 8th post-accept cycle; rsp_err=1, rsp_result=0, rsp_op=1; a late ack[1] afterwards is ignored.
- rsp_ready held low 5 cycles in RESP → rsp_* stable, cmd_ready=0, a cmd_valid during RESP is not accepted; after rsp_ready the next command is accepted in IDLE.
- rst asserted during WAIT_ACK → next cycle busy=0, cmd_ready=1, unit_start=0, rsp_valid=0; no response ever emitted for the aborted op.
